// File: rtl/score_display_scan_pkg.sv
// Shared definitions for the score display scanner.
// Holds the display limit, the idle digit code, the conversion FSM state
// type, the BCD nibble type and the double-dabble nibble adjust helper.
package score_display_scan_pkg;

   localparam int         MAX_DISPLAY = 9999;
   localparam logic [7:0] DIGIT_OFF   = 8'd0;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

   typedef logic [3:0] bcd_nibble_t;

   // Double-dabble correction: a nibble of 5 or more would overflow past 9
   // after the coming left shift, so pre-add 3 to carry into the next digit.
   function automatic bcd_nibble_t add3_if_ge5(input bcd_nibble_t n);
      return (n >= 4'd5) ? bcd_nibble_t'(n + 4'd3) : n;
   endfunction

endpackage

// File: rtl/score_display_scan_if.sv
// Score source / display bus.
//   value          binary score from game logic
//   value_valid    one-cycle strobe qualifying value
//   blank_leading  suppress leading zeros while high
//   busy           BCD conversion in progress
//   digit          BCD code (zero-extended) for the segment decoder
//   anode          active-low one-hot digit enable, bit 0 = ones digit
// master: score source side; slave: the scanner.
interface score_display_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14
);
   logic [VALUE_W-1:0]    value;
   logic                  value_valid;
   logic                  blank_leading;
   logic                  busy;
   logic [7:0]            digit;
   logic [NUM_DIGITS-1:0] anode;

   modport master (output value, value_valid, blank_leading,
                   input  busy, digit, anode);
   modport slave  (input  value, value_valid, blank_leading,
                   output busy, digit, anode);
endinterface

// File: rtl/score_display_scan_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD engine.
//   clk, rst  clock, asynchronous active-high reset
//   start     load bin, clear the BCD register, arm VALUE_W shift cycles
//   bin       binary operand (sampled on start)
//   done      high during the final shift cycle; bcd is complete after it
//   bcd       working BCD register, one nibble per digit
module score_display_scan_bin2bcd_seq
   import score_display_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [VALUE_W-1:0]             bin,
   output logic                           done,
   output bcd_nibble_t [NUM_DIGITS-1:0]   bcd
);
   localparam int CNT_W = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0]           bin_reg;
   bcd_nibble_t [NUM_DIGITS-1:0] bcd_reg;
   bcd_nibble_t [NUM_DIGITS-1:0] bcd_adj;
   logic [CNT_W-1:0]             cnt_reg;
   logic                         active_reg;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
         assign bcd_adj[gi] = add3_if_ge5(bcd_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_reg    <= '0;
         bcd_reg    <= '0;
         cnt_reg    <= '0;
         active_reg <= 1'b0;
      end else if (start) begin
         bin_reg    <= bin;
         bcd_reg    <= '0;
         cnt_reg    <= CNT_W'(VALUE_W);
         active_reg <= 1'b1;
      end else if (active_reg) begin
         // Adjust first, then shift the combined {bcd, bin} register left.
         {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
         cnt_reg            <= cnt_reg - CNT_W'(1);
         if (cnt_reg == CNT_W'(1)) begin
            active_reg <= 1'b0;
         end
      end
   end

   assign done = active_reg && (cnt_reg == CNT_W'(1));
   assign bcd  = bcd_reg;

endmodule

// File: rtl/score_display_scan.sv
// Score display scanner: converts a binary score to BCD and time-multiplexes
// it across a common-anode display through the shared segment decoder.
//   clk, rst  clock, asynchronous active-high reset
//   bus       slave side of score_display_scan_if (value, value_valid,
//             blank_leading in; busy, digit, anode out; all outputs registered)
module score_display_scan
   import score_display_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int VALUE_W     = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst,
   score_display_scan_if.slave bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int REF_W = $clog2(REFRESH_DIV);

   conv_state_t                  state_reg, state_next;
   logic [VALUE_W-1:0]           value_sat;
   logic [VALUE_W-1:0]           value_reg;
   logic [VALUE_W-1:0]           pending_reg;
   logic                         pending_flag_reg;
   bcd_nibble_t [NUM_DIGITS-1:0] disp_reg;
   logic                         busy_reg;
   logic                         eng_start;
   logic                         eng_done;
   bcd_nibble_t [NUM_DIGITS-1:0] eng_bcd;

   logic [REF_W-1:0]             refresh_cnt_reg;
   logic [IDX_W-1:0]             idx_reg;
   logic [NUM_DIGITS-1:0]        anode_reg;
   logic [7:0]                   digit_reg;
   logic [NUM_DIGITS:0]          upper_zero;
   logic                         blank_slot;

   assign value_sat = (32'(bus.value) > MAX_DISPLAY) ? VALUE_W'(MAX_DISPLAY) : bus.value;

   score_display_scan_bin2bcd_seq #(
      .NUM_DIGITS(NUM_DIGITS),
      .VALUE_W   (VALUE_W)
   ) u_bin2bcd (
      .clk  (clk),
      .rst  (rst),
      .start(eng_start),
      .bin  (value_reg),
      .done (eng_done),
      .bcd  (eng_bcd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      eng_start  = 1'b0;
      case (state_reg)
         IDLE:    if (bus.value_valid) state_next = LOAD;
         LOAD: begin
            eng_start  = 1'b1;
            state_next = SHIFT;
         end
         SHIFT:   if (eng_done) state_next = COMMIT;
         COMMIT:  state_next = (bus.value_valid || pending_flag_reg) ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand, pending slot and displayed value. A strobe arriving while a
   // conversion runs parks in the pending slot (last wins); a strobe during
   // COMMIT is newer than anything parked, so it is taken directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_reg        <= '0;
         pending_reg      <= '0;
         pending_flag_reg <= 1'b0;
         disp_reg         <= '0;
         busy_reg         <= 1'b0;
      end else begin
         busy_reg <= (state_next != IDLE);
         case (state_reg)
            IDLE: begin
               if (bus.value_valid) value_reg <= value_sat;
            end
            COMMIT: begin
               disp_reg <= eng_bcd;
               if (bus.value_valid) begin
                  value_reg        <= value_sat;
                  pending_flag_reg <= 1'b0;
               end else if (pending_flag_reg) begin
                  value_reg        <= pending_reg;
                  pending_flag_reg <= 1'b0;
               end
            end
            default: begin
               if (bus.value_valid) begin
                  pending_reg      <= value_sat;
                  pending_flag_reg <= 1'b1;
               end
            end
         endcase
      end
   end

   // upper_zero[i]: every displayed nibble from i up to the MSB is zero.
   assign upper_zero[NUM_DIGITS] = 1'b1;
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
         assign upper_zero[gi] = (disp_reg[gi] == 4'd0) && upper_zero[gi+1];
      end
   endgenerate

   assign blank_slot = bus.blank_leading && (idx_reg != '0) && upper_zero[idx_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_cnt_reg <= '0;
         idx_reg         <= '0;
         anode_reg       <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
         digit_reg       <= DIGIT_OFF;
      end else begin
         if (refresh_cnt_reg == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
         end else begin
            refresh_cnt_reg <= refresh_cnt_reg + REF_W'(1);
         end
         if (blank_slot) begin
            anode_reg <= '1;
            digit_reg <= DIGIT_OFF;
         end else begin
            anode_reg <= ~(NUM_DIGITS'(1) << idx_reg);
            digit_reg <= {4'b0000, disp_reg[idx_reg]};
         end
      end
   end

   assign bus.busy  = busy_reg;
   assign bus.digit = digit_reg;
   assign bus.anode = anode_reg;

endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench for score_display_scan with a short refresh period.
module tb_score_display_scan;

   localparam int RD = 4;

   typedef struct {
      int         slot;
      logic [3:0] anode;
      logic [7:0] digit;
   } scan_exp_t;

   typedef struct {
      logic       chk_scan;
      logic [3:0] anode;
      logic [7:0] digit;
      logic       busy;
   } now_exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc;

   score_display_scan_if #(.NUM_DIGITS(4), .VALUE_W(14)) bus ();

   score_display_scan #(
      .NUM_DIGITS (4),
      .VALUE_W    (14),
      .REFRESH_DIV(RD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   scan_exp_t scan_q[$];
   now_exp_t  now_q[$];
   int        busy_q[$];
   string     note_q[$];

   int        n_cmp  = 0;
   int        n_fail = 0;
   int        busy_run = 0;
   int        slot_now;
   scan_exp_t se;
   now_exp_t  ne;
   int        eb;
   string     nm;

   // Monitor: all comparisons happen here, on the falling edge.
   always @(negedge clk) begin
      while (note_q.size() > 0) begin
         nm = note_q.pop_front();
         n_cmp++; n_fail++;
         $display("FAIL timeout %s: expected event never happened", nm);
      end
      if (now_q.size() > 0) begin
         ne = now_q.pop_front();
         if (ne.chk_scan) begin
            n_cmp++;
            if (bus.anode !== ne.anode) begin
               n_fail++;
               $display("FAIL now_anode: got %b want %b", bus.anode, ne.anode);
            end
            n_cmp++;
            if (bus.digit !== ne.digit) begin
               n_fail++;
               $display("FAIL now_digit: got %0d want %0d", bus.digit, ne.digit);
            end
         end
         n_cmp++;
         if (bus.busy !== ne.busy) begin
            n_fail++;
            $display("FAIL now_busy: got %b want %b", bus.busy, ne.busy);
         end
         $display("now check: anode=%b digit=%0d busy=%b", bus.anode, bus.digit, bus.busy);
      end
      if (rst) begin
         busy_run = 0;
      end else if (bus.busy === 1'b1) begin
         busy_run++;
      end else if (busy_run > 0) begin
         n_cmp++;
         if (busy_q.size() == 0) begin
            n_fail++;
            $display("FAIL busy_len: got unexpected busy run of %0d want none", busy_run);
         end else begin
            eb = busy_q.pop_front();
            if (busy_run != eb) begin
               n_fail++;
               $display("FAIL busy_len: got %0d want %0d", busy_run, eb);
            end else begin
               $display("busy run %0d cycles", busy_run);
            end
         end
         busy_run = 0;
      end
      if (!rst && cyc >= 1 && (cyc % RD) == 1 && scan_q.size() > 0) begin
         slot_now = ((cyc - 1) / RD) % 4;
         if (scan_q[0].slot == slot_now) begin
            se = scan_q.pop_front();
            n_cmp++;
            if (bus.anode !== se.anode || bus.digit !== se.digit) begin
               n_fail++;
               $display("FAIL scan_slot%0d: got anode=%b digit=%0d want anode=%b digit=%0d",
                        se.slot, bus.anode, bus.digit, se.anode, se.digit);
            end else begin
               $display("scan slot %0d anode=%b digit=%0d", se.slot, bus.anode, bus.digit);
            end
         end
      end
   end

   task automatic push_scan(input int slot, input logic [3:0] an, input logic [7:0] dg);
      scan_exp_t e;
      e.slot = slot; e.anode = an; e.digit = dg;
      scan_q.push_back(e);
   endtask

   task automatic push_now(input logic chk, input logic [3:0] an, input logic [7:0] dg,
                           input logic b);
      now_exp_t e;
      e.chk_scan = chk; e.anode = an; e.digit = dg; e.busy = b;
      now_q.push_back(e);
   endtask

   task automatic strobe(input logic [13:0] v);
      bus.value       = v;
      bus.value_valid = 1'b1;
      @(negedge clk);
      bus.value_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy === 1'b1) note_q.push_back("wait_idle");
      repeat (2) @(negedge clk);
   endtask

   task automatic drain_scan();
      int n = 0;
      while (scan_q.size() > 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (scan_q.size() > 0) begin
         note_q.push_back("scan_drain");
         scan_q.delete();
      end
   endtask

   task automatic convert(input logic [13:0] v);
      busy_q.push_back(16);
      strobe(v);
      wait_idle();
   endtask

   initial begin
      rst               = 1'b1;
      bus.value         = '0;
      bus.value_valid   = 1'b0;
      bus.blank_leading = 1'b0;
      push_now(1'b1, 4'b1110, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset scan: 0000 everywhere, wraps back to slot 0.
      push_scan(0, 4'b1110, 8'd0);
      push_scan(1, 4'b1101, 8'd0);
      push_scan(2, 4'b1011, 8'd0);
      push_scan(3, 4'b0111, 8'd0);
      push_scan(0, 4'b1110, 8'd0);
      drain_scan();

      convert(14'd1234);
      push_scan(0, 4'b1110, 8'd4);
      push_scan(1, 4'b1101, 8'd3);
      push_scan(2, 4'b1011, 8'd2);
      push_scan(3, 4'b0111, 8'd1);
      drain_scan();

      convert(14'd12000);
      push_scan(0, 4'b1110, 8'd9);
      push_scan(1, 4'b1101, 8'd9);
      push_scan(2, 4'b1011, 8'd9);
      push_scan(3, 4'b0111, 8'd9);
      drain_scan();

      bus.blank_leading = 1'b1;
      convert(14'd7);
      push_scan(0, 4'b1110, 8'd7);
      push_scan(1, 4'b1111, 8'd0);
      push_scan(2, 4'b1111, 8'd0);
      push_scan(3, 4'b1111, 8'd0);
      drain_scan();

      bus.blank_leading = 1'b0;
      repeat (2) @(negedge clk);
      push_scan(0, 4'b1110, 8'd7);
      push_scan(1, 4'b1101, 8'd0);
      push_scan(2, 4'b1011, 8'd0);
      push_scan(3, 4'b0111, 8'd0);
      drain_scan();

      // Back-to-back: 5 sampled at edge N, 42 at N+3, 99 at N+8.
      busy_q.push_back(32);
      strobe(14'd5);
      repeat (2) @(negedge clk);
      strobe(14'd42);
      repeat (4) @(negedge clk);
      strobe(14'd99);
      wait_idle();
      push_scan(0, 4'b1110, 8'd9);
      push_scan(1, 4'b1101, 8'd9);
      push_scan(2, 4'b1011, 8'd0);
      push_scan(3, 4'b0111, 8'd0);
      drain_scan();

      convert(14'd1111);
      push_scan(0, 4'b1110, 8'd1);
      push_scan(1, 4'b1101, 8'd1);
      push_scan(2, 4'b1011, 8'd1);
      push_scan(3, 4'b0111, 8'd1);
      drain_scan();

      // Reset mid-SHIFT of 5678 with 3333 pending.
      strobe(14'd5678);
      @(negedge clk);
      strobe(14'd3333);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      push_now(1'b1, 4'b1110, 8'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      push_now(1'b0, 4'b0000, 8'd0, 1'b0);
      push_scan(0, 4'b1110, 8'd0);
      push_scan(1, 4'b1101, 8'd0);
      push_scan(2, 4'b1011, 8'd0);
      push_scan(3, 4'b0111, 8'd0);
      drain_scan();

      repeat (2) @(negedge clk);
      if (busy_q.size() != 0) note_q.push_back("busy_runs");
      if (now_q.size() != 0) note_q.push_back("now_checks");
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
